// File: rtl/conv_pool.sv
// conv_pool: ReLU + 2x2/2 max pool + u8 requant over the conv output memory.
// Reads one window at a time and streams one byte per window.
module conv_pool #(
   parameter  int DSIZE  = 256,
   parameter  int RD_LAT = 1,
   parameter  int DW     = 32,
   localparam int AW     = $clog2(DSIZE) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [7:0]    map_width,
   input  logic [7:0]    map_height,
   input  logic [4:0]    shift,
   output logic [AW-1:0] mo_addr,
   input  logic [DW-1:0] mo_data,
   output logic [7:0]    pool_data,
   output logic          pool_valid,
   input  logic          pool_ready,
   output logic          pool_last,
   output logic          busy,
   output logic          done
);

   typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, FIN} state_t;

   state_t state, nxt;

   logic [7:0]    w_q, ow, oh, ox, oy;
   logic [4:0]    sh;
   logic [15:0]   base, row_base, cur;
   logic [1:0]    rcnt, ccnt;
   logic [RD_LAT-1:0] vp;
   logic [DW-1:0] mx, relu, mx_nxt, q;
   logic [AW-1:0] addr_q;
   logic          cap, hs, last_win, zero;

   assign zero     = (map_width[7:1] == 7'd0) || (map_height[7:1] == 7'd0);
   assign cap      = vp[RD_LAT-1];
   assign hs       = (state == EMIT) && pool_valid && pool_ready;
   assign last_win = (ox == ow - 8'd1) && (oy == oh - 8'd1);

   // rcnt walks the window: +0, +1, +W, +W+1
   assign cur = base
              + (rcnt[1] ? {8'd0, w_q} : 16'd0)
              + {15'd0, rcnt[0]};

   assign mo_addr = (state == READ) ? cur[AW-1:0] : addr_q;
   assign relu    = mo_data[DW-1] ? '0 : mo_data;
   assign mx_nxt  = (ccnt == 2'd0 || relu > mx) ? relu : mx;
   assign q       = mx_nxt >> sh;
   assign busy    = (state == READ) || (state == WAIT) || (state == EMIT);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (start) nxt = zero ? FIN : READ;
         READ: if (rcnt == 2'd3) nxt = WAIT;
         WAIT: if (cap && ccnt == 2'd3) nxt = EMIT;
         EMIT: if (hs) nxt = last_win ? FIN : READ;
         FIN:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vp         <= '0;
         w_q        <= '0;
         ow         <= '0;
         oh         <= '0;
         ox         <= '0;
         oy         <= '0;
         sh         <= '0;
         base       <= '0;
         row_base   <= '0;
         rcnt       <= '0;
         ccnt       <= '0;
         mx         <= '0;
         addr_q     <= '0;
         pool_data  <= '0;
         pool_valid <= 1'b0;
         pool_last  <= 1'b0;
         done       <= 1'b0;
      end else begin
         vp[0] <= (state == READ);
         for (int i = 1; i < RD_LAT; i++) vp[i] <= vp[i-1];
         if (state == IDLE && start) begin
            w_q      <= map_width;
            ow       <= map_width >> 1;
            oh       <= map_height >> 1;
            sh       <= shift;
            ox       <= '0;
            oy       <= '0;
            base     <= '0;
            row_base <= '0;
            rcnt     <= '0;
            ccnt     <= '0;
            done     <= 1'b0;
         end
         if (state == READ) begin
            addr_q <= cur[AW-1:0];
            rcnt   <= rcnt + 2'd1;
         end
         if (cap) begin
            mx   <= mx_nxt;
            ccnt <= ccnt + 2'd1;
            if (ccnt == 2'd3) begin
               pool_valid <= 1'b1;
               pool_data  <= (|q[DW-1:8]) ? 8'hff : q[7:0];
               pool_last  <= last_win;
            end
         end
         if (hs) begin
            pool_valid <= 1'b0;
            pool_last  <= 1'b0;
            if (ox == ow - 8'd1) begin
               ox       <= '0;
               oy       <= oy + 8'd1;
               row_base <= row_base + {7'd0, w_q, 1'b0};
               base     <= row_base + {7'd0, w_q, 1'b0};
            end else begin
               ox   <= ox + 8'd1;
               base <= base + 16'd2;
            end
         end
         if (nxt == FIN) done <= 1'b1;
      end
   end

endmodule

// File: doc/conv_pool.md
Name: conv_pool

Overview:
- Post-processing stage directly downstream of the conv engine.
- After conv asserts done, it reads the conv output memory through the conv read port (mo_addr/mo_data) and applies ReLU.
- It then performs 2x2 stride-2 max pooling and requantizes each pooled value to unsigned 8-bit.
- Pooled pixels leave on a valid/ready byte stream toward the next layer's input loader.

Parameters:
- DSIZE, 256, depth of conv output memory in words; address width AW = $clog2(DSIZE)+1 (matches conv mo_addr).
- RD_LAT, 1, conv output memory read latency in cycles (1..3).
- DW, 32, width of one conv output word: one signed result per word.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a pooling pass; ignored while busy.
- map_width  in  8  conv output map width in words (row pitch).
- map_height  in  8  conv output map height in rows.
- shift  in  5  right-shift applied before saturation; sampled at start.
- mo_addr  out  AW  read address into conv output memory.
- mo_data  in  DW  read data, valid RD_LAT cycles after mo_addr.
- pool_data  out  8  pooled, requantized pixel.
- pool_valid  out  1  pool_data valid.
- pool_ready  in  1  downstream accepts when valid&ready.
- pool_last  out  1  high with the final pixel of the pass.
- busy  out  1  pass in progress.
- done  out  1  level; set at end of pass, cleared by next accepted start or rst.

Behaviour:
- Interface decisions: single clock clk; rst is synchronous and active-high.
- Reset values: mo_addr=0, pool_data=0, pool_valid=0, pool_last=0, busy=0, done=0, FSM=IDLE.
- Capture on start: map_width, map_height and shift are latched in the start cycle. Derived sizes: OW = map_width>>1, OH = map_height>>1. An odd trailing column or row is dropped.
- FSM states: IDLE, READ, WAIT, EMIT, FIN.
- IDLE -> READ on start. If OW==0 or OH==0: IDLE -> FIN with no reads and no stream output.
- READ issues 4 addresses on 4 consecutive cycles, in order: base, base+1, base+W, base+W+1, where base = 2*oy*W + 2*ox and W = latched map_width.
- Each mo_data is captured exactly RD_LAT cycles after its address. READ -> WAIT after the 4th address; WAIT lasts until the 4th datum is captured.
- Datapath per datum: relu = (signed value < 0) ? 0 : value; running max starts at 0 each window.
- Requantization: q = max >> shift. pool_data = (q > 255) ? 255 : q[7:0]. Arithmetic uses the full 32-bit width; there is no overflow inside the max.
- Stream output: pool_valid rises the cycle after the 4th capture (EMIT). First pool_valid occurs 4+RD_LAT+1 cycles after the start cycle.
- EMIT holds pool_data, pool_valid and pool_last stable until pool_valid & pool_ready. No next-window read is issued before that handshake.
- After the handshake: ox increments, wrapping to 0 with oy+1 at ox==OW-1. Next state is READ the following cycle, or FIN after the last window.
- Raster order: ox fastest; output count is OW*OH exactly.
- pool_last is asserted only with the window where ox==OW-1 and oy==OH-1.
- FIN: busy=0, done=1 for one cycle of transition, then IDLE with done held high.
- busy is high from the cycle after start through the final handshake.
- start while busy is ignored; latched parameters are unchanged.
- start in the same cycle as the final handshake is ignored. It is accepted only in IDLE.
- rst mid-pass: the next cycle restores all reset values and abandons the pass. In-flight read data is discarded; no stale pool_valid.
- mo_addr is held at the last issued value when not reading. Addresses never exceed map_width*map_height-1.

Test Plan:
- 6x6 map, word[r*6+c]=r*6+c, shift=0, pool_ready=1 -> 9 pixels 7,9,11,19,21,23,31,33,35. pool_last only on 35. done=1 after; first pool_valid 6 cycles after start (RD_LAT=1).
- Window {-5,-1,-300,-7}, shift=0 -> pool_data=0. Window {1000,3,-2,999}, shift=2 -> 250. Window {1100,0,0,0}, shift=2 -> 255 (saturated).
- 5x5 map of the same ramp -> exactly 4 pixels 6,8,16,18 (row 4 and column 4 unread). 1x8 map -> no stream output, done=1 within 3 cycles, no mo_addr activity.
- 6x6 ramp with pool_ready toggling 1-in-3 cycles -> pool_data/pool_valid stable while stalled. Same 9 values, no duplicates or drops. mo_addr does not advance during a stall.
- Second start pulse mid-pass, and RD_LAT=3 build -> first pass completes unchanged with correct values.
- rst asserted at the 4th output -> all outputs return to reset values next cycle. A fresh start then yields the full 9-pixel sequence from 7.
